// File: rtl/coin_acceptor.sv
// coin_acceptor: debounced fifty/dollar/cancel buttons feed a one-at-a-time
// pulse issuer, with credit tracking and vend/refund event counters.
module coin_acceptor #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned HOLDOFF_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_fifty,
   input  logic       btn_dollar,
   input  logic       btn_cancel,
   input  logic       insert_coin,
   input  logic       money_return,
   input  logic       dispense,
   output logic       fifty,
   output logic       dollar,
   output logic       cancel,
   output logic [1:0] credit,
   output logic [3:0] vend_count,
   output logic [3:0] refund_count,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0] HO_LOAD = 4'(HOLDOFF_CYCLES);

   // bit 0 = fifty, bit 1 = dollar, bit 2 = cancel
   logic [2:0]      btn_raw;
   logic [2:0]      sync1, sync2, deb, rise;
   logic [2:0]      req, req_clr;
   logic [2:0][7:0] db_cnt;

   state_t     state, state_nxt;
   logic [2:0] sel, sel_nxt;
   logic [3:0] hold_cnt, hold_nxt;

   logic       disp_q, ret_q;
   logic       disp_rise, ret_rise;
   logic [2:0] sum;
   logic [1:0] credit_nxt;

   assign btn_raw   = {btn_cancel, btn_dollar, btn_fifty};
   assign disp_rise = dispense & ~disp_q;
   assign ret_rise  = money_return & ~ret_q;

   // two-flop synchronizer on the raw buttons
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // accept a new level only after a full run of differing samples
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb    <= '0;
         db_cnt <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 8'd1;
            end
         end
      end
   end

   // debounced 0->1 happens on the cycle the counter completes
   always_comb begin
      rise = '0;
      for (int i = 0; i < 3; i++)
         rise[i] = sync2[i] & ~deb[i] & (db_cnt[i] == DB_LAST);
   end

   // sticky request flags; a fresh press beats a same-cycle clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) req <= '0;
      else      req <= (req & ~req_clr) | rise;
   end

   // FSM state, selected request and holdoff counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         sel      <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // arbitration: cancel > dollar > fifty; coins need insert_coin
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      hold_nxt  = hold_cnt;
      req_clr   = '0;
      unique case (state)
         IDLE: begin
            if (!insert_coin) req_clr[1:0] = 2'b11;
            if (req[2]) begin
               sel_nxt   = 3'b100;
               state_nxt = ISSUE;
            end else if (insert_coin && req[1]) begin
               sel_nxt   = 3'b010;
               state_nxt = ISSUE;
            end else if (insert_coin && req[0]) begin
               sel_nxt   = 3'b001;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            req_clr   = sel;
            hold_nxt  = HO_LOAD;
            state_nxt = HOLD;
         end
         HOLD: begin
            hold_nxt = hold_cnt - 4'd1;
            if (hold_cnt <= 4'd1) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // pulses decode from registered state only
   always_comb begin
      fifty  = (state == ISSUE) & sel[0];
      dollar = (state == ISSUE) & sel[1];
      cancel = (state == ISSUE) & sel[2];
      busy   = (state != IDLE);
   end

   // credit: clear on a transaction edge, add the coin, saturate at 3
   always_comb begin
      sum = (disp_rise | ret_rise) ? 3'd0 : {1'b0, credit};
      if (dollar)     sum = sum + 3'd2;
      else if (fifty) sum = sum + 3'd1;
      credit_nxt = (sum > 3'd3) ? 2'd3 : sum[1:0];
   end

   // edge-detect copies, credit and wrapping event counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp_q       <= 1'b0;
         ret_q        <= 1'b0;
         credit       <= '0;
         vend_count   <= '0;
         refund_count <= '0;
      end else begin
         disp_q <= dispense;
         ret_q  <= money_return;
         credit <= credit_nxt;
         if (disp_rise) vend_count   <= vend_count + 4'd1;
         if (ret_rise)  refund_count <= refund_count + 4'd1;
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: randomized and directed stimulus, a history-window
// reference model feeding a scoreboard queue, and a per-cycle monitor.
module tb_coin_acceptor;

   localparam int DB = 4;
   localparam int HO = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_fifty = 1'b0, btn_dollar = 1'b0, btn_cancel = 1'b0;
   logic       insert_coin = 1'b0, money_return = 1'b0, dispense = 1'b0;
   logic       fifty, dollar, cancel, busy;
   logic [1:0] credit;
   logic [3:0] vend_count, refund_count;

   coin_acceptor #(
      .DEBOUNCE_CYCLES(DB),
      .HOLDOFF_CYCLES (HO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_fifty   (btn_fifty),
      .btn_dollar  (btn_dollar),
      .btn_cancel  (btn_cancel),
      .insert_coin (insert_coin),
      .money_return(money_return),
      .dispense    (dispense),
      .fifty       (fifty),
      .dollar      (dollar),
      .cancel      (cancel),
      .credit      (credit),
      .vend_count  (vend_count),
      .refund_count(refund_count),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] pulse;
      logic       busy;
      logic [1:0] credit;
      logic [3:0] vend;
      logic [3:0] refund;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   rnd_misc = 0;

   // reference model state
   int unsigned hist [3];
   logic [2:0]  mdeb, pend, clr_sched, prev_pulse;
   int          k, free_edge, issue_edge;
   bit          issued, pd, pm;
   int          mcredit, mvend, mref;

   task automatic model_reset();
      for (int b = 0; b < 3; b++) hist[b] = 0;
      mdeb = '0; pend = '0; clr_sched = '0; prev_pulse = '0;
      k = 0; free_edge = 0; issue_edge = 0; issued = 0;
      pd = 0; pm = 0;
      mcredit = 0; mvend = 0; mref = 0;
   endtask

   task automatic model_step();
      logic [2:0]  raw, rise, drop, sel;
      int unsigned mask, win;
      int          add;
      bit          clr;
      exp_t        e;
      raw  = {btn_cancel, btn_dollar, btn_fifty};
      rise = '0; drop = '0; sel = '0;
      mask = (1 << DB) - 1;
      k++;
      // level accepted when the last DB synchronized samples agree
      for (int b = 0; b < 3; b++) begin
         hist[b] = (hist[b] << 1) | int'(raw[b]);
         win = (hist[b] >> 2) & mask;
         if (!mdeb[b] && win == mask) begin
            mdeb[b] = 1'b1;
            rise[b] = 1'b1;
         end else if (mdeb[b] && win == 0) begin
            mdeb[b] = 1'b0;
         end
      end
      if (k >= free_edge) begin
         if (!insert_coin) drop = 3'b011;
         if (pend[2])                     sel = 3'b100;
         else if (insert_coin && pend[1]) sel = 3'b010;
         else if (insert_coin && pend[0]) sel = 3'b001;
         if (sel != 0) begin
            issued     = 1;
            issue_edge = k;
            free_edge  = k + 2 + HO;
         end
      end
      pend      = (pend & ~clr_sched & ~drop) | rise;
      clr_sched = sel;
      add = prev_pulse[1] ? 2 : (prev_pulse[0] ? 1 : 0);
      clr = (dispense && !pd) || (money_return && !pm);
      if (dispense && !pd)     mvend = (mvend + 1) % 16;
      if (money_return && !pm) mref  = (mref + 1) % 16;
      pd = dispense;
      pm = money_return;
      mcredit = (clr ? 0 : mcredit) + add;
      if (mcredit > 3) mcredit = 3;
      prev_pulse = sel;
      e.pulse  = sel;
      e.busy   = issued && (k <= issue_edge + HO);
      e.credit = 2'(mcredit);
      e.vend   = 4'(mvend);
      e.refund = 4'(mref);
      sbq.push_back(e);
   endtask

   // model advances on every clock, cleared by reset
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         model_reset();
         sbq.delete();
      end else begin
         model_step();
      end
   end

   // monitor compares the DUT against the queued expectation mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         vectors++;
         if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: no expected entry at %0t", $time);
         end else begin
            e = sbq.pop_front();
            if ({cancel, dollar, fifty} !== e.pulse || busy !== e.busy ||
                credit !== e.credit || vend_count !== e.vend ||
                refund_count !== e.refund) begin
               miscompares++;
               $display("FAIL cycle@%0t: got pulse=%b busy=%b credit=%0d vend=%0d refund=%0d, expected pulse=%b busy=%b credit=%0d vend=%0d refund=%0d",
                        $time, {cancel, dollar, fifty}, busy, credit,
                        vend_count, refund_count, e.pulse, e.busy,
                        e.credit, e.vend, e.refund);
            end
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_btns(logic [2:0] v);
      {btn_cancel, btn_dollar, btn_fifty} = v;
   endtask

   task automatic step();
      if (rnd_misc) begin
         if ($urandom_range(0, 7) == 0) dispense = ~dispense;
         if ($urandom_range(0, 7) == 0) money_return = ~money_return;
         if ($urandom_range(0, 15) == 0) insert_coin = ~insert_coin;
      end
      @(negedge clk);
   endtask

   task automatic press(logic [2:0] m, int bounce, int hold, int gap);
      for (int i = 0; i < bounce; i++) begin
         set_btns(m & 3'($urandom));
         step();
      end
      set_btns(m);
      for (int i = 0; i < hold; i++) step();
      for (int i = 0; i < bounce; i++) begin
         set_btns(m & 3'($urandom));
         step();
      end
      set_btns(3'b000);
      for (int i = 0; i < gap; i++) step();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic release_rst();
      @(negedge clk);
      #2 rst = 1'b1;
   endtask

   initial begin
      idle(3);
      chk("reset_pulses", {cancel, dollar, fifty}, 0);
      chk("reset_busy", busy, 0);
      chk("reset_credit", credit, 0);
      chk("reset_vend", vend_count, 0);
      chk("reset_refund", refund_count, 0);
      release_rst();
      idle(5);

      // bouncy fifty press with coins accepted
      insert_coin = 1'b1;
      press(3'b001, 3, 10, 12);
      chk("fifty_credit", credit, 1);

      // dollar and fifty debounced together
      press(3'b011, 0, 8, 20);
      chk("both_credit", credit, 3);

      // dispense edge coincides with a fifty pulse
      btn_fifty = 1'b1;
      for (int i = 0; i < 30 && !fifty; i++) @(negedge clk);
      chk("wait_fifty", fifty, 1);
      dispense  = 1'b1;
      btn_fifty = 1'b0;
      idle(5);
      dispense = 1'b0;
      chk("disp_credit", credit, 1);
      chk("disp_vend", vend_count, 1);
      idle(5);

      // coin rejected while not ready, cancel still served
      insert_coin = 1'b0;
      press(3'b010, 2, 8, 15);
      chk("reject_credit", credit, 1);
      press(3'b100, 2, 8, 15);

      // sixteen refund edges wrap the counter
      for (int i = 0; i < 16; i++) begin
         money_return = 1'b1;
         idle(2);
         money_return = 1'b0;
         idle(2);
      end
      chk("refund_wrap", refund_count, 0);
      chk("refund_credit", credit, 0);

      // randomized traffic
      rnd_misc = 1;
      for (int n = 0; n < 300; n++) begin
         logic [2:0] m;
         m = 3'($urandom_range(1, 7));
         if ($urandom_range(0, 2) != 0) m = 3'(1 << $urandom_range(0, 2));
         press(m, $urandom_range(0, 4), $urandom_range(1, 10),
               $urandom_range(0, 8));
      end
      rnd_misc     = 0;
      dispense     = 1'b0;
      money_return = 1'b0;
      insert_coin  = 1'b1;
      idle(40);

      // reset lands during a dollar pulse
      btn_dollar = 1'b1;
      for (int i = 0; i < 40 && !dollar; i++) @(negedge clk);
      chk("wait_dollar", dollar, 1);
      #2;
      rst        = 1'b0;
      btn_dollar = 1'b0;
      #1;
      chk("rst_pulses", {cancel, dollar, fifty}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_credit", credit, 0);
      chk("rst_counts", {vend_count, refund_count}, 0);
      idle(2);
      release_rst();
      idle(30);

      // button held through reset release registers once
      @(negedge clk);
      #2 rst = 1'b0;
      btn_fifty = 1'b1;
      idle(2);
      release_rst();
      idle(12);
      btn_fifty = 1'b0;
      idle(20);
      chk("held_credit", credit, 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
